// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared types, command-word layout and reset constants for the DAC frame scheduler.
// Build option: DAC_MIDSCALE_START_EN selects mid-scale shadow reset and a frame forced right after reset.
package dac_sched_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND, HOLDOFF} state_t;

    localparam logic [1:0] LD_HOLD = 2'b00;
    localparam logic [1:0] LD_ALL  = 2'b01;

    localparam int CMD_LD_MSB = 21;
    localparam int CMD_LD_LSB = 20;
    localparam int CMD_CH_MSB = 18;
    localparam int CMD_CH_LSB = 17;

    localparam int HOLDOFF_CYCLES = 2;

`ifdef DAC_MIDSCALE_START_EN
    localparam logic [15:0] SHADOW_RST  = 16'h8000;
    localparam logic        START_FRAME = 1'b1;
`else
    localparam logic [15:0] SHADOW_RST  = 16'h0000;
    localparam logic        START_FRAME = 1'b0;
`endif

    function automatic logic [23:0] dac_cmd(input logic [1:0] ld, input logic [1:0] ch, input logic [15:0] val);
        logic [23:0] w;
        w = {8'h00, val};
        w[CMD_LD_MSB:CMD_LD_LSB] = ld;
        w[CMD_CH_MSB:CMD_CH_LSB] = ch;
        return w;
    endfunction

endpackage

// File: rtl/dac_frame_scheduler_sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO.
// Ports: clk, rst_n (async, active-low); wr_en/wr_data write side (ignored when full);
//        rd_en/rd_data pop side (rd_data valid whenever !empty); full, empty, level status.
module sample_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_ok, rd_ok;

    always_comb begin
        full     = level_q == (AW+1)'(DEPTH);
        empty    = level_q == '0;
        wr_ok    = wr_en && !full;
        rd_ok    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        level_d  = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        rd_data  = mem_q[rd_ptr_q];
        level    = level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler: queues per-channel samples and, on each sample tick, sends one frame of DAC command words.
// Ports: i_Clock, reset_n (async, active-low); i_Sample_Data/Ch/Valid + o_Sample_Ready sample input;
//        o_DAC_Data/o_DAC_Send + i_DAC_Ready SPI-stage handshake; o_Overrun sticky flag cleared by i_Clear;
//        o_Fifo_Level sample FIFO occupancy.
// Build option: DAC_MIDSCALE_START_EN (mid-scale shadows and a frame forced right after reset).
module dac_frame_scheduler
    import dac_sched_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_Clock,
    input  logic                          reset_n,
    input  logic [15:0]                   i_Sample_Data,
    input  logic [1:0]                    i_Sample_Ch,
    input  logic                          i_Sample_Valid,
    output logic                          o_Sample_Ready,
    output logic [23:0]                   o_DAC_Data,
    output logic                          o_DAC_Send,
    input  logic                          i_DAC_Ready,
    output logic                          o_Overrun,
    input  logic                          i_Clear,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Level
);

    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [1:0]  hold_q, hold_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] data_q, data_d;
    logic        overrun_q, overrun_d;
    logic        start_q, start_d;
    logic [15:0] shadow_q [4];
    logic [15:0] shadow_d [4];

    logic        tick, pop, fifo_full, fifo_empty;
    logic [17:0] fifo_rd_data;

    sample_fifo #(
        .WIDTH (18),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_Clock),
        .rst_n   (reset_n),
        .wr_en   (i_Sample_Valid),
        .wr_data ({i_Sample_Ch, i_Sample_Data}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_Fifo_Level)
    );

    always_comb begin
        tick      = cnt_q == 16'(SAMPLE_DIV - 1);
        state_d   = state_q;
        ch_d      = ch_q;
        hold_d    = hold_q;
        data_d    = data_q;
        shadow_d  = shadow_q;
        start_d   = start_q;
        pop       = 1'b0;
        cnt_d     = tick ? 16'd0 : cnt_q + 16'd1;
        // A tick landing outside IDLE is dropped; recording it beats a simultaneous clear.
        overrun_d = (tick && state_q != IDLE) ? 1'b1 : i_Clear ? 1'b0 : overrun_q;
        case (state_q)
            IDLE: begin
                if (tick || start_q) begin
                    state_d = WAIT_RDY;
                    ch_d    = 2'd0;
                    start_d = 1'b0;
                    // The forced start-up frame re-phases the tick counter.
                    if (start_q) cnt_d = 16'd0;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (int'(fifo_rd_data[17:16]) < NUM_CH) shadow_d[fifo_rd_data[17:16]] = fifo_rd_data[15:0];
                end
            end
            WAIT_RDY: begin
                if (i_DAC_Ready) begin
                    data_d  = dac_cmd(ch_q == LAST_CH ? LD_ALL : LD_HOLD, ch_q, shadow_q[ch_q]);
                    state_d = SEND;
                end
            end
            SEND: begin
                // The SEND cycle itself is the first cycle of the ready-ignore window.
                hold_d  = 2'(HOLDOFF_CYCLES - 2);
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_q != 2'd0) begin
                    hold_d = hold_q - 2'd1;
                end else if (ch_q == LAST_CH) begin
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = WAIT_RDY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ch_q      <= 2'd0;
            hold_q    <= 2'd0;
            cnt_q     <= 16'd0;
            data_q    <= 24'd0;
            overrun_q <= 1'b0;
            start_q   <= START_FRAME;
            shadow_q  <= '{default: SHADOW_RST};
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            start_q   <= start_d;
            shadow_q  <= shadow_d;
        end
    end

    always_comb begin
        o_DAC_Send     = state_q == SEND;
        o_DAC_Data     = data_q;
        o_Overrun      = overrun_q;
        o_Sample_Ready = !fifo_full;
    end

endmodule
